// File: rtl/mdio_controller_if.sv
// Signal bundle between the MDIO station-management master, its host and the PHY.
// master: the controller's view; slave: the host/PHY side driving requests and MDIO_IN.
interface mdio_controller_if;
    logic        MDIO_START;
    logic [31:0] T_DATA;
    logic        MDIO_IN;
    logic        MDC;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic [15:0] RD_DATA;
    logic        DATA_RDY;
    logic        BUSY;

    modport master (
        input  MDIO_START, T_DATA, MDIO_IN,
        output MDC, MDIO_OUT, MDIO_OE, RD_DATA, DATA_RDY, BUSY
    );

    modport slave (
        output MDIO_START, T_DATA, MDIO_IN,
        input  MDC, MDIO_OUT, MDIO_OE, RD_DATA, DATA_RDY, BUSY
    );
endinterface

// File: rtl/mdio_controller.sv
// MDIO (Clause-22) station-management master.
// Takes a 32-bit frame on a start strobe, derives MDC from CLK (MDC_HALF CLK cycles
// per half-period) and shifts the frame out MSB-first. Read frames release the line
// from bit 14 on and capture bits 16..31 from MDIO_IN into RD_DATA.
// Optional macro MDIO_PREAMBLE_EN: prefixes each frame with 32 bit periods of ones.
module mdio_controller #(
    parameter int MDC_HALF = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    mdio_controller_if.master bus
);

    localparam logic [1:0] IDLE  = 2'd0;
`ifdef MDIO_PREAMBLE_EN
    localparam logic [1:0] PRE   = 2'd1;
`endif
    localparam logic [1:0] FRAME = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [7:0] HALF_RELOAD = 8'(MDC_HALF - 1);
    localparam logic [5:0] LAST_BIT    = 6'd31;
    localparam logic [5:0] TA_BIT      = 6'd14;
    localparam logic [5:0] CAP_BIT     = 6'd16;

    logic [1:0]  state;
    logic [5:0]  bit_cnt;
    logic [7:0]  div_cnt;
    logic [31:0] shreg;
    logic        is_read;
    logic [15:0] cap;
    logic [5:0]  next_cnt;
    logic        next_out;
    logic        next_oe;

    assign next_cnt = bit_cnt + 6'd1;

    // Line level for the upcoming bit period: preamble ones, the next frame bit, or released after turnaround
    always_comb begin
        next_out = 1'b1;
        next_oe  = 1'b1;
        if (state == FRAME) begin
            if (is_read && (next_cnt >= TA_BIT)) begin
                next_out = 1'b0;
                next_oe  = 1'b0;
            end else begin
                next_out = shreg[30];
            end
        end
    end

    // Frame sequencer: MDC divider, bit counter, serialiser and read-data capture
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            div_cnt      <= '0;
            shreg        <= '0;
            is_read      <= 1'b0;
            cap          <= '0;
            bus.MDC      <= 1'b0;
            bus.MDIO_OUT <= 1'b0;
            bus.MDIO_OE  <= 1'b0;
            bus.RD_DATA  <= '0;
            bus.DATA_RDY <= 1'b0;
            bus.BUSY     <= 1'b0;
        end else begin
            bus.DATA_RDY <= 1'b0;
            if (state == IDLE) begin
                bus.MDC <= 1'b0;
                if (bus.MDIO_START) begin
                    shreg       <= bus.T_DATA;
                    is_read     <= (bus.T_DATA[29:28] == 2'b10);
                    cap         <= '0;
                    bit_cnt     <= '0;
                    div_cnt     <= HALF_RELOAD;
                    bus.BUSY    <= 1'b1;
                    bus.MDIO_OE <= 1'b1;
`ifdef MDIO_PREAMBLE_EN
                    state        <= PRE;
                    bus.MDIO_OUT <= 1'b1;
`else
                    state        <= FRAME;
                    bus.MDIO_OUT <= bus.T_DATA[31];
`endif
                end
            end else if (state == DONE) begin
                state <= IDLE;
            end else if (div_cnt != 8'd0) begin
                div_cnt <= div_cnt - 8'd1;
            end else begin
                div_cnt <= HALF_RELOAD;
                if (!bus.MDC) begin
                    bus.MDC <= 1'b1;
                end else begin
                    bus.MDC <= 1'b0;
                    if ((state == FRAME) && is_read && (bit_cnt >= CAP_BIT)) begin
                        cap <= {cap[14:0], bus.MDIO_IN};
                    end
                    if (bit_cnt != LAST_BIT) begin
                        bit_cnt      <= next_cnt;
                        bus.MDIO_OUT <= next_out;
                        bus.MDIO_OE  <= next_oe;
                        if (state == FRAME) begin
                            shreg <= {shreg[30:0], 1'b0};
                        end
                    end
`ifdef MDIO_PREAMBLE_EN
                    else if (state == PRE) begin
                        state        <= FRAME;
                        bit_cnt      <= '0;
                        bus.MDIO_OUT <= shreg[31];
                        bus.MDIO_OE  <= 1'b1;
                    end
`endif
                    else begin
                        state        <= DONE;
                        div_cnt      <= '0;
                        bus.MDIO_OUT <= 1'b0;
                        bus.MDIO_OE  <= 1'b0;
                        bus.BUSY     <= 1'b0;
                        if (is_read) begin
                            bus.RD_DATA  <= {cap[14:0], bus.MDIO_IN};
                            bus.DATA_RDY <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mdio_controller.sv
// Testbench for mdio_controller: two instances (MDC_HALF=1 and 3) driven with directed
// and $urandom frames; every CLK cycle is compared against a timeline model derived
// from bit index and MDC phase arithmetic.
module tb_mdio_controller;

    localparam int HALF_A = 1;
    localparam int HALF_B = 3;
`ifdef MDIO_PREAMBLE_EN
    localparam int PRE_BITS = 32;
`else
    localparam int PRE_BITS = 0;
`endif

    logic CLK = 1'b0;
    logic RESET = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;
    logic [15:0] rd_model [2];

    mdio_controller_if bus_a ();
    mdio_controller_if bus_b ();

    mdio_controller #(.MDC_HALF(HALF_A)) dut_a (.CLK(CLK), .RESET(RESET), .bus(bus_a));
    mdio_controller #(.MDC_HALF(HALF_B)) dut_b (.CLK(CLK), .RESET(RESET), .bus(bus_b));

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic drive(input int sel, input logic start, input logic [31:0] t, input logic din);
        if (sel == 0) begin
            bus_a.MDIO_START = start;
            bus_a.T_DATA     = t;
            bus_a.MDIO_IN    = din;
        end else begin
            bus_b.MDIO_START = start;
            bus_b.T_DATA     = t;
            bus_b.MDIO_IN    = din;
        end
    endtask

    // Packed view {MDC, MDIO_OUT, MDIO_OE, BUSY, DATA_RDY}
    function automatic logic [4:0] observe(input int sel);
        if (sel == 0)
            return {bus_a.MDC, bus_a.MDIO_OUT, bus_a.MDIO_OE, bus_a.BUSY, bus_a.DATA_RDY};
        return {bus_b.MDC, bus_b.MDIO_OUT, bus_b.MDIO_OE, bus_b.BUSY, bus_b.DATA_RDY};
    endfunction

    function automatic logic [15:0] observe_rd(input int sel);
        return (sel == 0) ? bus_a.RD_DATA : bus_b.RD_DATA;
    endfunction

    // Expected outputs in cycle c (c=1 is the cycle after the accepting edge)
    function automatic logic [4:0] model_vec(input int c, input int half, input logic [31:0] t, input logic rd);
        int bits;
        int k;
        int n;
        logic mdc;
        logic o;
        logic oe;
        bits = PRE_BITS + 32;
        if (c <= 2 * half * bits) begin
            k   = (c - 1) / (2 * half);
            mdc = (((c - 1) % (2 * half)) >= half);
            if (k < PRE_BITS) begin
                o  = 1'b1;
                oe = 1'b1;
            end else begin
                n = k - PRE_BITS;
                if (rd && n >= 14) begin
                    o  = 1'b0;
                    oe = 1'b0;
                end else begin
                    o  = t[31 - n];
                    oe = 1'b1;
                end
            end
            return {mdc, o, oe, 1'b1, 1'b0};
        end
        if (c == 2 * half * bits + 1)
            return {4'b0000, rd};
        return 5'b00000;
    endfunction

    // PHY-side bit presented during cycle c: read data for bits 16..31 of a read, noise otherwise
    function automatic logic phy_bit(input int c, input int half, input logic rd, input logic [15:0] phy);
        int n;
        n = (c - 1) / (2 * half) - PRE_BITS;
        if (rd && n >= 16 && n <= 31)
            return phy[31 - n];
        return 1'($urandom);
    endfunction

    // One complete frame on instance sel, optionally with a stray start at bit 20
    task automatic applyStimulus(input int sel, input logic [31:0] t, input logic [15:0] phy, input bit inject);
        int half;
        int last;
        int c_inj;
        int rises;
        logic rd;
        logic prev_mdc;
        logic [4:0] obs;
        half     = (sel == 0) ? HALF_A : HALF_B;
        last     = 2 * half * (PRE_BITS + 32) + 2;
        c_inj    = 2 * half * (PRE_BITS + 20) + 1;
        rd       = (t[29:28] == 2'b10);
        rises    = 0;
        prev_mdc = 1'b0;
        drive(sel, 1'b1, t, 1'b0);
        @(posedge CLK);
        for (int c = 1; c <= last; c++) begin
            @(negedge CLK);
            obs = observe(sel);
            checkOutput($sformatf("h%0d_t%h_c%0d", half, t, c), 32'(obs), 32'(model_vec(c, half, t, rd)));
            if (obs[4] && !prev_mdc) rises++;
            prev_mdc = obs[4];
            if (inject && c == c_inj)
                drive(sel, 1'b1, 32'h5000FFFF, phy_bit(c, half, rd, phy));
            else
                drive(sel, 1'b0, $urandom, phy_bit(c, half, rd, phy));
        end
        drive(sel, 1'b0, 32'h0, 1'b0);
        if (rd) rd_model[sel] = phy;
        checkOutput($sformatf("mdc_rises_h%0d", half), 32'(rises), 32'(PRE_BITS + 32));
        checkOutput($sformatf("rd_data_h%0d", half), 32'(observe_rd(sel)), 32'(rd_model[sel]));
    endtask

    // Abort a read frame at bit 10 with an asynchronous reset
    task automatic resetMidFrame();
        logic [31:0] t;
        int c_abort;
        t = $urandom;
        t[29:28] = 2'b10;
        c_abort = 2 * HALF_A * (PRE_BITS + 10) + 1;
        drive(0, 1'b1, t, 1'b0);
        @(posedge CLK);
        for (int c = 1; c <= c_abort; c++) begin
            @(negedge CLK);
            checkOutput($sformatf("pre_abort_c%0d", c), 32'(observe(0)), 32'(model_vec(c, HALF_A, t, 1'b1)));
            drive(0, 1'b0, $urandom, 1'b1);
        end
        #1 RESET = 1'b0;
        #1;
        rd_model[0] = 16'h0;
        rd_model[1] = 16'h0;
        checkOutput("abort_outputs", 32'(observe(0)), 32'h0);
        checkOutput("abort_rd_data", 32'(observe_rd(0)), 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        for (int c = 0; c < 2 * HALF_A * (PRE_BITS + 32) + 4; c++) begin
            @(negedge CLK);
            checkOutput($sformatf("post_abort_idle_c%0d", c), 32'(observe(0)), 32'h0);
        end
        checkOutput("post_abort_rd_b", 32'(observe_rd(1)), 32'(rd_model[1]));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] t;
        rd_model[0] = 16'h0;
        rd_model[1] = 16'h0;
        drive(0, 1'b0, 32'h0, 1'b0);
        drive(1, 1'b0, 32'h0, 1'b0);
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("reset_a", 32'(observe(0)), 32'h0);
        checkOutput("reset_b", 32'(observe(1)), 32'h0);
        checkOutput("reset_rd_a", 32'(observe_rd(0)), 32'h0);
        RESET = 1'b1;
        @(negedge CLK);
        checkOutput("idle_a", 32'(observe(0)), 32'h0);

        applyStimulus(0, 32'h508EBEEF, 16'h0000, 1'b0);
        applyStimulus(0, 32'h608C0000, 16'h2AAA, 1'b0);
        applyStimulus(0, 32'h508EBEEF, 16'h0000, 1'b1);
        for (int i = 0; i < 8; i++) begin
            t = $urandom;
            if ($urandom_range(0, 1) == 1) t[29:28] = 2'b10;
            applyStimulus(0, t, 16'($urandom), 1'($urandom));
        end

        applyStimulus(1, 32'h508E0001, 16'h0000, 1'b0);
        applyStimulus(1, 32'h608C0000, 16'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) begin
            t = $urandom;
            if ($urandom_range(0, 1) == 1) t[29:28] = 2'b10;
            applyStimulus(1, t, 16'($urandom), 1'($urandom));
        end

        resetMidFrame();
        t = $urandom;
        t[29:28] = 2'b10;
        applyStimulus(0, t, 16'($urandom), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
